// File: rtl/imm_ext_pkg.sv
// Shared constants and types for the immediate-extension arbiter slice.
package imm_ext_pkg;

    localparam int IMM_W_DEF  = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] MODE_SIGN = 2'b00;
    localparam logic [1:0] MODE_ZERO = 2'b01;
    localparam logic [1:0] MODE_LUI  = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender: sign, zero, lui, or illegal (zero data, err set).
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    localparam int EXT_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] zext_s;

    assign zext_s = {{EXT_W{1'b0}}, imm_i};

    // Mode decode into the extended result
    always_comb begin
        data_o = {DATA_W{1'b0}};
        err_o  = 1'b0;
        case (mode_i)
            MODE_SIGN: data_o = {{EXT_W{imm_i[IMM_W-1]}}, imm_i};
            MODE_ZERO: data_o = zext_s;
            MODE_LUI:  data_o = zext_s << IMM_W;
            MODE_ILL: begin
                data_o = {DATA_W{1'b0}};
                err_o  = 1'b1;
            end
            default: begin
                data_o = {DATA_W{1'b0}};
                err_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between two requesters,
// with a single-entry valid/ready result register.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [IMM_W-1:0]  req0_imm_i,
    input  logic [1:0]        req0_mode_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [IMM_W-1:0]  req1_imm_i,
    input  logic [1:0]        req1_mode_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_id_o,
    output logic              rsp_err_o
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;

    logic              grant0_s, grant1_s;
    logic              slot_free_s;
    logic              accept0_s, accept1_s;
    logic [IMM_W-1:0]  sel_imm_s;
    logic [1:0]        sel_mode_s;
    logic [DATA_W-1:0] ext_data_s;
    logic              ext_err_s;

    // Round-robin grant: on a tie the port that did not win last time goes
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant0_s = last_grant_q;
            grant1_s = ~last_grant_q;
        end else begin
            grant0_s = req0_valid_i;
            grant1_s = req1_valid_i;
        end
    end

    // Readies stay low during reset so nothing is taken while state is cleared
    assign slot_free_s  = ~rst_i & ((state_q == ST_EMPTY) | rsp_ready_i);
    assign req0_ready_o = slot_free_s & grant0_s;
    assign req1_ready_o = slot_free_s & grant1_s;
    assign accept0_s    = req0_valid_i & req0_ready_o;
    assign accept1_s    = req1_valid_i & req1_ready_o;

    assign sel_imm_s  = grant1_s ? req1_imm_i  : req0_imm_i;
    assign sel_mode_s = grant1_s ? req1_mode_i : req0_mode_i;

    imm_ext_unit #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_ext (
        .imm_i  (sel_imm_s),
        .mode_i (sel_mode_s),
        .data_o (ext_data_s),
        .err_o  (ext_err_s)
    );

    // Next-state for the result slot, its payload and the fairness pointer
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        if (accept0_s || accept1_s) begin
            state_d      = ST_FULL;
            last_grant_d = accept1_s;
            rsp_data_d   = ext_data_s;
            rsp_id_d     = accept1_s;
            rsp_err_d    = ext_err_s;
        end else if ((state_q == ST_FULL) && rsp_ready_i) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State and result register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_EMPTY;
            last_grant_q <= 1'b1;
            rsp_data_q   <= {DATA_W{1'b0}};
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid_o = (state_q == ST_FULL);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shares one immediate-extension unit between two requesters, decode (port 0) and the load/store address path (port 1), in the MIPS datapath. Each request carries a 16-bit immediate and an extension mode. The block arbitrates round-robin, extends the winning immediate, and holds the 32-bit result in a single-entry output register under a valid/ready handshake. Sustained throughput is one result per cycle; latency is one cycle.

## Interface
- IMM_W, 16, immediate width
- DATA_W, 32, result width (must be ≥ 2·IMM_W)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req0_valid_i  in  1  port 0 request valid
- req0_ready_o  out  1  port 0 request accepted this cycle
- req0_imm_i  in  IMM_W  port 0 immediate
- req0_mode_i  in  2  port 0 mode: 00 sign, 01 zero, 10 lui, 11 illegal
- req1_valid_i / req1_ready_o / req1_imm_i / req1_mode_i  same as port 0, for port 1
- rsp_valid_o  out  1  result register holds a valid result
- rsp_ready_i  in  1  consumer takes the result this cycle
- rsp_data_o  out  DATA_W  extended result
- rsp_id_o  out  1  requester index the result belongs to
- rsp_err_o  out  1  request used illegal mode 11

## Operation
- Extension modes:
  - sign: imm replicated from bit IMM_W-1 into the upper bits.
  - zero: upper bits 0.
  - lui: imm in bits [DATA_W-1:IMM_W], lower bits 0.
  - illegal (11): data 0, err 1.
- Two-state FSM:
  - EMPTY → FULL on accept.
  - FULL → FULL on simultaneous drain and accept.
  - FULL → EMPTY on drain with no accept.
  - EMPTY stays EMPTY with no valid request.
- slot_free = EMPTY | (FULL & rsp_ready_i).
- Grant is combinational from the valids and the last_grant pointer:
  - Only one port valid: that port wins.
  - Both valid: the port ≠ last_grant wins.
- reqN_ready_o = slot_free & grantN. At most one ready is high per cycle. Ready never asserts for a port whose valid is low.
- A request is accepted on valid & ready. On accept:
  - The result register loads data, id and err.
  - last_grant updates to the accepted port.
- With no accept, last_grant holds.
- Once rsp_valid_o is high, rsp_data_o, rsp_id_o and rsp_err_o stay stable until the cycle after rsp_ready_i.
- Requesters may drop or change valid/imm/mode before acceptance. No requester-side stability is required.
- Fairness: with both ports continuously valid and the consumer always ready, grants alternate 0,1,0,1…. No port waits more than one accepted transaction.

## Timing
- Reset values:
  - rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0.
  - FSM=EMPTY, last_grant=1, so port 0 wins the first tie.
- Both ready outputs are 0 while rst_i is high.
- Latency: accept at edge N; rsp_valid_o high and data valid from N through at least the edge where rsp_ready_i is sampled high.
- Back-to-back: drain and accept at the same edge gives continuous rsp_valid_o with new data the next cycle, with no bubble.
- Backpressure: FULL & !rsp_ready_i forces both readies low. Requests wait with no loss.
- Reset mid-operation: a held result is discarded, rsp_valid_o=0 at the next edge, and pending requests are not accepted during reset.
- No combinational path from reqN_* to rsp_*. Paths exist from rsp_ready_i and reqN_valid_i to reqN_ready_o.

## Structure
- Package imm_ext_pkg holds:
  - Mode constants: MODE_SIGN=2'b00, MODE_ZERO=2'b01, MODE_LUI=2'b10, MODE_ILL=2'b11.
  - FSM state constants: ST_EMPTY, ST_FULL.
  - Default IMM_W and DATA_W.
- Sub-module imm_ext_unit: purely combinational (imm, mode) → (data, err). It is instantiated once after the grant mux, which keeps the extension logic single and shared.
- The top level holds the arbiter, last_grant, the FSM and the result register.

## Test plan
- Reset, then port 0 sign request imm=16'h8001 with consumer ready → req0_ready_o=1 that cycle; next cycle rsp_valid_o=1, rsp_data_o=32'hFFFF8001, rsp_id_o=0, rsp_err_o=0.
- Port 1 zero 16'h8001, then lui 16'h1234, then mode 11 imm 16'hFFFF → in order: 32'h00008001/id1/err0, 32'h12340000/id1/err0, 32'h00000000/id1/err1.
- Both ports valid every cycle for 6 cycles, consumer always ready → accepts alternate 0,1,0,1,0,1 and rsp_valid_o stays high from the 2nd cycle with no bubble.
- Result held with rsp_ready_i=0 for 4 cycles while port 1 is valid → req1_ready_o=0 and rsp_data_o stable throughout; in the cycle rsp_ready_i=1, req1 is accepted and the new result appears the next cycle.
- rst_i asserted for one cycle while FULL with an unaccepted request pending → rsp_valid_o=0 after that edge and no accept during reset; next tie goes to port 0.
